addsub_arbiter: RTL
===================

Name: addsub_arbiter

Overview:
- Shares one AddSub2 add/subtract datapath between two independent requesters.
- Each requester uses a valid/ready handshake on both request and response.
- Arbitration is round-robin; the result is registered and held until the owning requester accepts it.
- Sits between client blocks (sequencers, accumulators) and the single shared arithmetic unit.

Parameters:
- WIDTH, 8, operand/result width in bits, passed through to the AddSub2 instance; must be >= 2.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  2  bit i: requester i presents an operation
- req_ready  output  2  bit i: arbiter accepts requester i this cycle
- req0_a  input  WIDTH  requester 0 operand a
- req0_b  input  WIDTH  requester 0 operand b
- req0_sub  input  1  requester 0: 0 = a+b, 1 = a-b
- req1_a  input  WIDTH  requester 1 operand a
- req1_b  input  WIDTH  requester 1 operand b
- req1_sub  input  1  requester 1 operation select
- rsp_valid  output  2  bit i: result for requester i is available
- rsp_ready  input  2  bit i: requester i consumes its result
- rsp_out  output  WIDTH  registered result (shared bus; qualify with rsp_valid)
- rsp_ovf  output  1  registered signed-overflow flag
- busy  output  1  high in any state other than IDLE
- owner  output  1  index of the requester currently granted or served

Behaviour:
- Reset (rst high at a clock edge):
  - state=IDLE, prio=0, owner=0.
  - Operand registers cleared; rsp_out=0, rsp_ovf=0.
  - rsp_valid=00, busy=0.
  - req_ready is forced 00 while rst is high.
  - Reset mid-operation discards any in-flight operation and any unconsumed result; no response is issued for it.
- State machine states: IDLE, EXEC, RESP.
- IDLE:
  - req_ready is combinational from req_valid and prio.
  - Only one requester valid: that one is granted.
  - Both valid: the requester indexed by prio is granted.
  - Exactly one req_ready bit is high when any req_valid bit is high; none otherwise.
  - On handshake (valid and ready): latch a, b, sub of the winner and set owner. Next state EXEC.
- EXEC (1 cycle):
  - AddSub2 operates combinationally on the latched operands.
  - rsp_out and rsp_ovf are registered at the end of the cycle. Next state RESP.
- RESP:
  - rsp_valid[owner]=1; rsp_valid[~owner]=0.
  - rsp_out and rsp_ovf are held stable until rsp_ready[owner] is high at a clock edge.
  - On that edge: prio <= ~owner, rsp_valid clears, next state IDLE.
  - rsp_ready from the non-owner is ignored.
- Latency and throughput:
  - Request handshake at edge N gives rsp_valid high from edge N+2.
  - Minimum spacing between request accepts is 3 cycles.
  - No request is accepted while busy.
- Arithmetic:
  - rsp_out = (a + b) mod 2^WIDTH, or (a - b) mod 2^WIDTH when sub=1.
  - rsp_ovf is two's-complement overflow:
    - add: a[MSB]==b[MSB] and out[MSB]!=a[MSB]
    - sub: a[MSB]!=b[MSB] and out[MSB]!=a[MSB]
- Fairness: a requester that holds req_valid continuously is granted within at most 2 grants, since prio always flips to the non-served requester.
- A requester may drop req_valid before being granted without side effects; the arbiter never latches a non-handshaked request.
- owner holds its value in IDLE; it updates only on grant.

Decomposition:
- Shared header arith_defs.vh holds:
  - state encodings ST_IDLE=2'd0, ST_EXEC=2'd1, ST_RESP=2'd2
  - requester index constants REQ0=1'b0, REQ1=1'b1
- Sub-module: one instance of the existing AddSub2 #(WIDTH), ports (a, b, sub, ovf, out), fed from the operand registers.
- Arbitration, FSM and result registers live in addsub_arbiter itself.

Test Plan:
1. Reset then single add, WIDTH=2: req_valid=01, a=1, b=1, sub=0 → req_ready=01 in the same cycle; rsp_valid=01 two edges later with rsp_out=2, rsp_ovf=1; rsp_ready=01 → rsp_valid=00, busy=0.
2. Subtract corner, WIDTH=2: requester 1, a=0, b=1, sub=1 → rsp_out=3, rsp_ovf=0, owner=1. Then a=2, b=1, sub=1 → rsp_out=1, rsp_ovf=1.
3. Contention, WIDTH=8: both valid continuously from reset, requester 0 with 5+3 and requester 1 with 10-4 → grant order 0,1,0,1; results 8 and 6 on the respective rsp_valid bits; rsp_ovf=0.
4. Backpressure: hold rsp_ready=00 for 10 cycles in RESP → rsp_out, rsp_ovf and rsp_valid stay stable; req_ready=00 throughout even with req_valid=11; rsp_ready from the non-owner causes no state change.
5. Reset mid-operation: assert rst during EXEC and during RESP → next cycle state IDLE, rsp_valid=00, rsp_out=0, prio=0; the next grant with req_valid=11 goes to requester 0.
6. Random regression, WIDTH=8: 2000 randomized valid/ready/operand patterns checked against a reference model for rsp_out/rsp_ovf → no mismatches, no lost or duplicated responses, neither requester starved (max 2 grants between services).

Source files
------------

// File: rtl/addsub_arbiter_pkg.sv
// Shared types and helpers for the two-requester add/sub arbiter.
// State encodings, requester indices and the round-robin pick.
package addsub_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam logic REQ0 = 1'b0;
   localparam logic REQ1 = 1'b1;

   // One-hot grant: a lone requester wins, a tie goes to prio.
   function automatic logic [1:0] rr_pick(input logic [1:0] v,
                                          input logic p);
      logic [1:0] g;
      g = 2'b00;
      unique case (v)
         2'b01:   g = 2'b01;
         2'b10:   g = 2'b10;
         2'b11:   g = p ? 2'b10 : 2'b01;
         default: g = 2'b00;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/addsub_arbiter_addsub2.sv
// AddSub2: combinational add/subtract with two's-complement overflow.
// Shared arithmetic unit fed from the arbiter's operand registers.
module AddSub2 #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             ovf,
   output logic [WIDTH-1:0] out
);

   logic sa, sb, so;

   assign out = sub ? (a - b) : (a + b);
   assign sa  = a[WIDTH-1];
   assign sb  = b[WIDTH-1];
   assign so  = out[WIDTH-1];

   // Overflow when the effective operand signs agree but the result flips.
   assign ovf = (sub ? (sa != sb) : (sa == sb)) && (so != sa);

endmodule

// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one AddSub2 between two requesters.
// Result is registered and held until the owning requester takes it.
module addsub_arbiter
   import addsub_arbiter_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       req_valid,
   output logic [1:0]       req_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req0_sub,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic             req1_sub,
   output logic [1:0]       rsp_valid,
   input  logic [1:0]       rsp_ready,
   output logic [WIDTH-1:0] rsp_out,
   output logic             rsp_ovf,
   output logic             busy,
   output logic             owner
);

   state_t           state, state_n;
   logic             prio;
   logic [WIDTH-1:0] op_a, op_b;
   logic             op_sub;
   logic [WIDTH-1:0] alu_out;
   logic             alu_ovf;
   logic [1:0]       gnt;
   logic             take, win;

   AddSub2 #(.WIDTH(WIDTH)) u_alu (
      .a   (op_a),
      .b   (op_b),
      .sub (op_sub),
      .ovf (alu_ovf),
      .out (alu_out)
   );

   assign win  = gnt[1];
   assign take = |(req_valid & gnt);
   assign busy = (state != ST_IDLE);

   always_comb begin
      state_n   = state;
      gnt       = 2'b00;
      rsp_valid = 2'b00;
      unique case (state)
         ST_IDLE: begin
            if (!rst) gnt = rr_pick(req_valid, prio);
            if (take) state_n = ST_EXEC;
         end
         ST_EXEC: state_n = ST_RESP;
         ST_RESP: begin
            rsp_valid[owner] = 1'b1;
            if (rsp_ready[owner]) state_n = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   assign req_ready = gnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         prio    <= REQ0;
         owner   <= REQ0;
         op_a    <= '0;
         op_b    <= '0;
         op_sub  <= 1'b0;
         rsp_out <= '0;
         rsp_ovf <= 1'b0;
      end else begin
         state <= state_n;
         unique case (state)
            ST_IDLE: begin
               if (take) begin
                  owner  <= win;
                  op_a   <= win ? req1_a   : req0_a;
                  op_b   <= win ? req1_b   : req0_b;
                  op_sub <= win ? req1_sub : req0_sub;
               end
            end
            ST_EXEC: begin
               rsp_out <= alu_out;
               rsp_ovf <= alu_ovf;
            end
            ST_RESP: begin
               if (rsp_ready[owner]) prio <= ~owner;
            end
            default: ;
         endcase
      end
   end

endmodule
